// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states and digit limits.
package stopwatch_bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} sw_state_e;

  localparam int         NUM_DIG  = 6;
  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  // Seconds-tens and minutes-tens wrap at 5; every other digit wraps at 9.
  function automatic logic [3:0] dig_max(input int idx);
    return (idx == 3 || idx == 5) ? DIG_MAX5 : DIG_MAX9;
  endfunction
endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// One BCD digit: wraps at MAX, synchronous clear has priority over increment.
module bcd_digit_cnt #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);
  logic [3:0] q_q, q_d;
  logic       at_max;

  // >= keeps an out-of-range value from ever counting through A-F.
  assign at_max = (q_q >= MAX);

  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (inc) q_d = at_max ? 4'd0 : q_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc & at_max;
endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.cc stopwatch: run/pause FSM, centisecond prescaler, six-digit BCD ripple counter.
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [4:0] dig0,
  output logic [4:0] dig1,
  output logic [4:0] dig2,
  output logic [4:0] dig3,
  output logic [4:0] dig4,
  output logic [4:0] dig5,
  output logic       running,
  output logic       rollover
);
  localparam int            DIV      = CLK_HZ / TICK_HZ;
  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  sw_state_e                 state_q, state_d;
  logic [PW-1:0]             pre_q, pre_d;
  logic                      tick, running_q, rollover_q, rollover_d;
  logic [NUM_DIG-1:0]        inc, carry;
  logic [NUM_DIG-1:0][3:0]   dig_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_stop && !clear) state_d = RUN;
      RUN:     if (clear) state_d = IDLE; else if (start_stop) state_d = PAUSE;
      PAUSE:   if (clear) state_d = IDLE; else if (start_stop) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

  // Prescaler only advances while staying in RUN, so every entry to RUN starts a full period.
  always_comb begin
    pre_d = '0;
    if (state_q == RUN && state_d == RUN)
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
  end

  assign inc        = {carry[NUM_DIG-2:0], tick};
  assign rollover_d = carry[NUM_DIG-1] & ~clear;

  generate
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
      bcd_digit_cnt #(.MAX(dig_max(i))) u_dig (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (inc[i]),
        .q     (dig_q[i]),
        .carry (carry[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      running_q  <= (state_d == RUN);
      rollover_q <= rollover_d;
    end
  end

  assign dig0     = {1'b0, dig_q[0]};
  assign dig1     = {1'b0, dig_q[1]};
  assign dig2     = {1'b1, dig_q[2]};
  assign dig3     = {1'b0, dig_q[3]};
  assign dig4     = {1'b1, dig_q[4]};
  assign dig5     = {1'b0, dig_q[5]};
  assign running  = running_q;
  assign rollover = rollover_q;
endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ clocks per count (centisecond).
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start_stop  input  1  single-cycle pulse from upstream debounce/edge-detect; toggles run/pause.
REQ-006 clear  input  1  single-cycle pulse; zeroes time and returns to idle.
REQ-007 dig0..dig5  output  5 each  display digits, format {dp,hex[3:0]}, dp=1 lit; dig0 is least significant.
REQ-008 running  output  1  high while in RUN state.
REQ-009 rollover  output  1  one-cycle pulse when time wraps 59:59.99 -> 00:00.00.

Function
REQ-010 Digit map: dig0 centi units 0-9, dig1 centi tens 0-9, dig2 sec units 0-9, dig3 sec tens 0-5, dig4 min units 0-9, dig5 min tens 0-5.
REQ-011 dp bits constant: dig2[4]=1, dig4[4]=1, all others 0.
REQ-012 FSM states IDLE, RUN, PAUSE; reset state IDLE.
REQ-013 IDLE: start_stop -> RUN; time held at zero.
REQ-014 RUN: start_stop -> PAUSE; clear -> IDLE.
REQ-015 PAUSE: start_stop -> RUN; clear -> IDLE; time frozen.
REQ-016 clear and start_stop in same cycle: clear wins, next state IDLE, start_stop ignored.
REQ-017 clear in IDLE: no effect beyond holding zero.
REQ-018 Prescaler counts 0..DIV-1 only in RUN; forced to 0 in IDLE and PAUSE, so each entry to RUN restarts a full DIV period.
REQ-019 Tick asserted for one cycle when prescaler = DIV-1 in RUN; first tick DIV cycles after the cycle start_stop is sampled.
REQ-020 Digit outputs update on the clock edge following the tick cycle (registered, latency 1 cycle from tick).
REQ-021 Each digit increments when all lower digits are at their maximum and tick is high; at its maximum it wraps to 0 (ripple BCD carry, same cycle).
REQ-022 At 59:59.99 a tick yields 00:00.00, rollover=1 for exactly that one cycle, state remains RUN.
REQ-023 clear zeroes all digits on the next edge regardless of pending tick; clear beats tick in the same cycle.
REQ-024 Digit values never leave their legal ranges (no hex A-F output).
REQ-025 running is registered, equal to (state==RUN).

Reset
REQ-026 rst low asynchronously forces state IDLE, prescaler 0, all digit hex fields 0, running 0, rollover 0.
REQ-027 dp bits are constant and read per REQ-011 during and after reset.
REQ-028 Reset mid-RUN discards progress; after release the block is in IDLE awaiting start_stop.

Structure
REQ-029 Shared package holds the FSM state enumeration (IDLE/RUN/PAUSE) and digit maximum constants (9, 5).
REQ-030 One sub-module bcd_digit_cnt (parameter MAX; inputs clk, rst, clr, inc; outputs q[3:0], carry) instanced six times.
REQ-031 No combinational path from start_stop or clear to any output.

Verification (CLK_HZ=1000, TICK_HZ=100, DIV=10)
REQ-032 Reset release, no stimulus for 100 cycles -> all hex 0, dig2[4]=dig4[4]=1, running=0.
REQ-033 start_stop pulse, run 10 cycles -> dig0=1 on cycle 11; after 1000 cycles total -> dig2=1, dig0=dig1=0.
REQ-034 Pause after 25 ticks, wait 500 cycles, resume -> digits stay 25 centi while paused; next increment exactly 10 cycles after resume.
REQ-035 Preload via run to 59:59.99 (or force), one tick -> all hex 0, rollover high exactly one cycle, running=1.
REQ-036 clear and start_stop same cycle while RUN -> IDLE, digits 0, running=0 next cycle.
REQ-037 rst asserted mid-count at 12:34.56 asynchronously -> outputs zero without clock edge; after release start_stop required to count.
